// File: rtl/uart_tx_flow_if.sv
// Host write port of the UART transmitter: write strobe, data and FIFO/status flags.
// No latency of its own; carries only wires between the host and the transmitter.
// The host must observe full before writing; writes while full are dropped and flagged.
interface uart_tx_flow_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  full;
   logic                  empty;
   logic                  overflow;
   logic                  busy;
   logic                  intrpt;

   modport master (
      output wr_en,
      output wr_data,
      input  full,
      input  empty,
      input  overflow,
      input  busy,
      input  intrpt
   );

   modport slave (
      input  wr_en,
      input  wr_data,
      output full,
      output empty,
      output overflow,
      output busy,
      output intrpt
   );
endinterface

// File: rtl/uart_tx_flow.sv
// UART serial transmitter with a write FIFO and CTS flow control; optional parity via UART_TX_PARITY_EN.
// Latency: start bit appears 1 cycle after the first baud tick that follows a write (>=1 cycle later).
// Backpressure: writes while full are dropped and set sticky overflow; cts_n gates frame start only.
module uart_tx_flow #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 8
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           baud_clk,
   uart_tx_flow_if.slave  host,
   input  logic           cfg_stop2,
   input  logic           cfg_parity_en,
   input  logic           cfg_parity_odd,
   input  logic           cts_n,
   output logic           txd
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = $clog2(DATA_WIDTH);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd4
   } state_t;
`endif

   // write FIFO storage and bookkeeping
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic                  overflow_q;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  push;
   logic                  pop;
   logic [DATA_WIDTH-1:0] head;

   // transmitter state
   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   logic                  stop_cnt_q, stop_cnt_d;
   logic                  stop2_q;
   logic                  txd_q, txd_d;
   logic                  intrpt_q, intrpt_d;
   logic                  start_ok;

`ifdef UART_TX_PARITY_EN
   logic                  par_en_q;
   logic                  par_bit_q;
`else
   logic                  unused_parity_cfg;
   assign unused_parity_cfg = cfg_parity_en ^ cfg_parity_odd;
`endif

   // Flags come from the registered count, so a pop never frees room for a same-cycle write.
   assign fifo_full  = (count == CW'(FIFO_DEPTH));
   assign fifo_empty = (count == '0);
   assign push       = host.wr_en && !fifo_full;
   assign head       = mem[rd_ptr];
   assign start_ok   = !fifo_empty && !cts_n;

   assign host.full     = fifo_full;
   assign host.empty    = fifo_empty;
   assign host.overflow = overflow_q;
   assign host.busy     = (state_q != IDLE);
   assign host.intrpt   = intrpt_q;
   assign txd           = txd_q;

   // FIFO data array; contents need no reset because count gates every read
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= host.wr_data;
      end
   end

   // FIFO pointers, occupancy and sticky overflow; reset flushes the queue
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (host.wr_en && fifo_full) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // state register; the frame config is captured together with the popped character
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         stop2_q    <= 1'b0;
         txd_q      <= 1'b1;
         intrpt_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         txd_q      <= txd_d;
         intrpt_q   <= intrpt_d;
         if (pop) begin
            shift_q   <= head;
            stop2_q   <= cfg_stop2;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= cfg_parity_en;
            par_bit_q <= (^head) ^ cfg_parity_odd;
`endif
         end else begin
            shift_q <= shift_d;
         end
      end
   end

   // next state and next txd; txd_d is the level of the state being entered on this tick
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      txd_d      = txd_q;
      intrpt_d   = 1'b0;
      pop        = 1'b0;
      if (baud_clk) begin
         case (state_q)
            IDLE: begin
               if (start_ok) begin
                  state_d = START;
                  pop     = 1'b1;
                  txd_d   = 1'b0;
               end
            end
            START: begin
               state_d   = DATA;
               bit_cnt_d = '0;
               txd_d     = shift_q[0];
            end
            DATA: begin
               if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                  if (par_en_q) begin
                     state_d = PARITY;
                     txd_d   = par_bit_q;
                  end else begin
                     state_d    = STOP;
                     stop_cnt_d = 1'b0;
                     txd_d      = 1'b1;
                  end
`else
                  state_d    = STOP;
                  stop_cnt_d = 1'b0;
                  txd_d      = 1'b1;
`endif
               end else begin
                  shift_d   = shift_q >> 1;
                  bit_cnt_d = bit_cnt_q + BW'(1);
                  txd_d     = shift_q[1];
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               state_d    = STOP;
               stop_cnt_d = 1'b0;
               txd_d      = 1'b1;
            end
`endif
            STOP: begin
               if (stop2_q && !stop_cnt_q) begin
                  stop_cnt_d = 1'b1;
               end else if (start_ok) begin
                  // next frame follows with no idle gap
                  state_d = START;
                  pop     = 1'b1;
                  txd_d   = 1'b0;
               end else begin
                  state_d  = IDLE;
                  txd_d    = 1'b1;
                  intrpt_d = fifo_empty;
               end
            end
            default: begin
               state_d = IDLE;
               txd_d   = 1'b1;
            end
         endcase
      end
   end
endmodule
